seq_calculator: RTL and testbench
=================================

Name: seq_calculator

Overview:
- Parametrised, sequential successor to the 4-bit switch calculator datapath.
- Performs add, subtract, multiply and divide on two WIDTH-bit unsigned operands under a start/busy/done handshake.
- Multiply is iterative shift-add; divide is iterative restoring.
- Results are registered and held for the BCD converter / seven-segment display path and the LEDs.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..16); the result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- clr  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation select: 00 add, 01 sub, 10 div, 11 mul (same encoding as btn[1:0]).
- a  input  WIDTH  operand A (dividend for div).
- b  input  WIDTH  operand B (divisor for div).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking result valid.
- result  output  2*WIDTH  sum, difference, product or quotient.
- remainder  output  WIDTH  division remainder; 0 for other ops.
- negative  output  1  sub only: 1 when a < b.
- div_by_zero  output  1  div only: 1 when b == 0.

Behaviour:
- Reset: clk and clr are the only clock and reset. Reset is synchronous and active-high.
  - While clr = 1 at an edge: state = IDLE; busy, done, result, remainder, negative and div_by_zero all clear to 0; iteration counter = 0.
  - clr has priority over every other input.
  - clr asserted mid-operation aborts the operation; no done pulse is issued.
- States:
  - IDLE: busy = 0. On an edge with start = 1, latch a, b and op internally, then:
    - ADD/SUB go to EXEC.
    - MUL/DIV with b != 0 go to ITER with counter = 0.
    - DIV with b == 0 goes to EXEC.
  - EXEC: single compute cycle, then go to DONE.
  - ITER: one multiply/divide step per cycle. Counter increments each cycle; after WIDTH steps go to DONE.
  - DONE: done = 1 and busy = 0 for exactly one cycle, then return to IDLE.
    - start sampled in the DONE cycle is ignored; a new start must arrive in IDLE.
- busy:
  - = 1 in EXEC and ITER, 0 otherwise.
  - start while busy is ignored; latched operands are unaffected by input changes after acceptance.
- Latency, measured from the accepting edge E0:
  - ADD/SUB and div-by-zero: done high in the cycle after E2 (outputs registered at E2).
  - MUL/DIV: done high after edge E(WIDTH+2).
- Arithmetic (all unsigned inputs):
  - ADD: result = a + b zero-extended; the carry appears at bit WIDTH. negative = 0, div_by_zero = 0.
  - SUB: result = a - b as a 2*WIDTH-bit two's-complement value (sign-extended). negative = (a < b).
  - MUL: result = a * b, full 2*WIDTH bits. Shift-add over WIDTH steps: add the multiplicand into the upper accumulator when the multiplier LSB = 1, then shift right.
  - DIV (b != 0): result = a / b zero-extended; remainder = a % b. Restoring algorithm over WIDTH steps: shift {rem, quo} left; trial-subtract b; restore if negative; the quotient bit is the complement of the sign.
  - DIV (b == 0): result = all ones (2*WIDTH bits); remainder = a; div_by_zero = 1.
- Output hold: result, remainder, negative and div_by_zero update only when entering DONE. They hold their values through IDLE until the next operation completes, so the display stays stable.
  - Intermediate iteration registers are internal and never visible on result.
- Boundaries:
  - a = b = 0 for every op: result 0, except DIV, which is the div-by-zero case.
  - Maximum operands must not overflow the 2*WIDTH result.
  - start held high continuously: a new operation is accepted on each IDLE cycle, giving back-to-back ops separated by a DONE cycle and an IDLE cycle.

Test Plan:
- Setup: WIDTH = 8 for all scenarios.
- Reset mid-op: start MUL a = 200, b = 3; assert clr at iteration 4 → next cycle busy = 0, result = 0, no done; a fresh ADD afterwards works normally.
- ADD a = 255, b = 1 → done at E0+2, result = 0x0100, negative = 0. SUB a = 3, b = 5 → result = 0xFFFE, negative = 1.
- MUL a = 255, b = 255 → busy for 9 cycles, done after E10, result = 0xFE01, remainder = 0. Changing a/b while busy → result unchanged.
- DIV a = 200, b = 7 → result = 28, remainder = 4 after E10. DIV a = 5, b = 9 → result = 0, remainder = 5.
- DIV a = 42, b = 0 → done at E0+2, result = 0xFFFF, remainder = 42, div_by_zero = 1; the next ADD clears div_by_zero.
- Start held high for 3 ops with op changing → each accepted only in IDLE, one done pulse per op, outputs hold between pulses; start pulses while busy produce no extra done.

Source files
------------

// File: rtl/seq_calculator.sv
// seq_calculator: sequential add/sub/mul/div unit with a start/busy/done
// handshake. Multiply is shift-add and divide is restoring, both iterating
// one bit per clock. Results are registered and held for the display path.
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 negative,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpDiv = 2'b10;
  localparam logic [1:0] OpMul = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_count;
  // r_hi is the upper accumulator (mul) or partial remainder (div);
  // r_lo is the multiplier being shifted out (mul) or the quotient (div).
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_mulAcc;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH+1:0] w_divTrial;
  logic             w_divNeg;

  // Single-cycle arithmetic and the per-step mul/div datapath
  always_comb begin
    w_sum      = {1'b0, r_a} + {1'b0, r_b};
    w_diff     = {1'b0, r_a} - {1'b0, r_b};
    w_mulAcc   = r_lo[0] ? (r_hi + {1'b0, r_a}) : r_hi;
    w_divShift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_divTrial = {1'b0, w_divShift} - {2'b00, r_b};
    w_divNeg   = w_divTrial[WIDTH+1];
  end

  // State register; clr aborts any operation in flight
  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (op == OpAdd || op == OpSub || (op == OpDiv && b == '0))
            w_nextState = EXEC;
          else
            w_nextState = ITER;
        end
      end
      EXEC: begin
        busy        = 1'b1;
        w_nextState = DONE;
      end
      ITER: begin
        busy = 1'b1;
        if (r_count == LastCount) w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand capture, iteration steps and result registers (written only when entering DONE)
  always_ff @(posedge clk) begin
    if (clr) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_count     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      result      <= '0;
      remainder   <= '0;
      negative    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= (op == OpMul) ? b : a;
          end
        end
        EXEC: begin
          if (r_op == OpAdd) begin
            result      <= {{(WIDTH-1){1'b0}}, w_sum};
            remainder   <= '0;
            negative    <= 1'b0;
            div_by_zero <= 1'b0;
          end else if (r_op == OpSub) begin
            result      <= {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
            remainder   <= '0;
            negative    <= w_diff[WIDTH];
            div_by_zero <= 1'b0;
          end else begin
            result      <= '1;
            remainder   <= r_a;
            negative    <= 1'b0;
            div_by_zero <= 1'b1;
          end
        end
        ITER: begin
          if (r_count == LastCount) begin
            negative    <= 1'b0;
            div_by_zero <= 1'b0;
            if (r_op == OpMul) begin
              result    <= {r_hi[WIDTH-1:0], r_lo};
              remainder <= '0;
            end else begin
              result    <= {{WIDTH{1'b0}}, r_lo};
              remainder <= r_hi[WIDTH-1:0];
            end
          end else begin
            r_count <= r_count + CW'(1);
            if (r_op == OpMul) begin
              r_hi <= {1'b0, w_mulAcc[WIDTH:1]};
              r_lo <= {w_mulAcc[0], r_lo[WIDTH-1:1]};
            end else begin
              r_hi <= w_divNeg ? w_divShift : w_divTrial[WIDTH:0];
              r_lo <= {r_lo[WIDTH-2:0], ~w_divNeg};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: scoreboard bench for seq_calculator at WIDTH = 8.
// Expected outputs are pushed when an operation is driven and popped when
// the DUT pulses done.
module tb_seq_calculator;

  localparam int W = 8;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic [W-1:0]   rem;
    logic           neg;
    logic           dbz;
  } outs_t;

  logic           clk = 1'b0;
  logic           clr;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           negative;
  logic           div_by_zero;

  int    vectors     = 0;
  int    miscompares = 0;
  outs_t expQ[$];

  seq_calculator #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .remainder(remainder),
    .negative(negative), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model of the four operations
  function automatic outs_t calcModel(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    outs_t r;
    r = '0;
    case (o)
      2'b00: r.res = 16'(x) + 16'(y);
      2'b01: begin r.res = 16'(x) - 16'(y); r.neg = (x < y); end
      2'b10: begin
        if (y == 0) begin r.res = 16'hFFFF; r.rem = x; r.dbz = 1'b1; end
        else begin r.res = 16'(x / y); r.rem = x % y; end
      end
      default: r.res = 16'(x) * 16'(y);
    endcase
    return r;
  endfunction

  // Drive one op, push its expectation, wait (bounded) for done, then step one more edge
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               input bit scramble, output outs_t obs, output int latency,
                               output int busyCycles, output logic doneAfter);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    expQ.push_back(calcModel(o, x, y));
    latency = 0; busyCycles = 0; obs = '0;
    while (latency < 40) begin
      @(posedge clk); #1;
      latency++;
      if (done) begin
        obs = {result, remainder, negative, div_by_zero};
        start = 1'b0;
        break;
      end
      if (busy) begin
        busyCycles++;
        if (scramble) begin
          start = 1'($urandom_range(0, 1));
          a = W'($urandom); b = W'($urandom);
        end else start = 1'b0;
      end else start = 1'b0;
    end
    @(posedge clk); #1;
    doneAfter = done;
  endtask

  task automatic test_reset;
    clr = 1'b1; start = 1'b1; op = 2'b11; a = 8'd9; b = 8'd9;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, result, remainder, negative, div_by_zero} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b res=%h rem=%h neg=%b dbz=%b, want all zero",
               busy, done, result, remainder, negative, div_by_zero);
    end
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
  endtask

  task automatic test_add_sub;
    outs_t obs, exp; int lat, bc; logic da;
    applyStimulus(2'b00, 8'd255, 8'd1, 1'b0, obs, lat, bc, da);
    exp = expQ.pop_front();
    vectors++;
    if (obs !== exp || obs.res !== 16'h0100) begin
      miscompares++;
      $display("[TB] FAIL add_255_1: got res=%h neg=%b, want res=%h neg=%b", obs.res, obs.neg, exp.res, exp.neg);
    end
    vectors++;
    if (lat !== 2 || bc !== 1 || da !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_latency: got lat=%0d busy=%0d doneAfter=%b, want 2/1/0", lat, bc, da);
    end
    applyStimulus(2'b01, 8'd3, 8'd5, 1'b0, obs, lat, bc, da);
    exp = expQ.pop_front();
    vectors++;
    if (obs !== exp || obs.res !== 16'hFFFE || obs.neg !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sub_3_5: got res=%h neg=%b, want res=%h neg=%b", obs.res, obs.neg, exp.res, exp.neg);
    end
  endtask

  task automatic test_mul;
    outs_t obs, exp; int lat, bc; logic da;
    applyStimulus(2'b11, 8'd255, 8'd255, 1'b1, obs, lat, bc, da);
    exp = expQ.pop_front();
    vectors++;
    if (obs !== exp || obs.res !== 16'hFE01) begin
      miscompares++;
      $display("[TB] FAIL mul_255_255: got res=%h rem=%h, want res=%h rem=%h", obs.res, obs.rem, exp.res, exp.rem);
    end
    vectors++;
    if (lat !== 10 || bc !== 9 || da !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mul_timing: got lat=%0d busy=%0d doneAfter=%b, want 10/9/0", lat, bc, da);
    end
    applyStimulus(2'b11, 8'd13, 8'd11, 1'b0, obs, lat, bc, da);
    exp = expQ.pop_front();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL mul_13_11: got res=%h, want res=%h", obs.res, exp.res);
    end
  endtask

  task automatic test_div;
    outs_t obs, exp, held; int lat, bc; logic da;
    applyStimulus(2'b10, 8'd200, 8'd7, 1'b0, obs, lat, bc, da);
    exp = expQ.pop_front();
    vectors++;
    if (obs !== exp || obs.res !== 16'd28 || obs.rem !== 8'd4) begin
      miscompares++;
      $display("[TB] FAIL div_200_7: got q=%0d r=%0d, want q=%0d r=%0d", obs.res, obs.rem, exp.res, exp.rem);
    end
    vectors++;
    if (lat !== 10) begin
      miscompares++;
      $display("[TB] FAIL div_latency: got %0d, want 10", lat);
    end
    applyStimulus(2'b10, 8'd5, 8'd9, 1'b0, obs, lat, bc, da);
    exp = expQ.pop_front();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL div_5_9: got q=%0d r=%0d, want q=%0d r=%0d", obs.res, obs.rem, exp.res, exp.rem);
    end
    a = 8'd77; b = 8'd1; op = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    held = {result, remainder, negative, div_by_zero};
    vectors++;
    if (held !== exp || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL output_hold: got res=%h rem=%h busy=%b, want res=%h rem=%h busy=0",
               held.res, held.rem, busy, exp.res, exp.rem);
    end
  endtask

  task automatic test_div_by_zero;
    outs_t obs, exp; int lat, bc; logic da;
    applyStimulus(2'b10, 8'd42, 8'd0, 1'b0, obs, lat, bc, da);
    exp = expQ.pop_front();
    vectors++;
    if (obs !== exp || obs.dbz !== 1'b1 || obs.rem !== 8'd42) begin
      miscompares++;
      $display("[TB] FAIL div_by_zero: got res=%h rem=%0d dbz=%b, want res=%h rem=%0d dbz=%b",
               obs.res, obs.rem, obs.dbz, exp.res, exp.rem, exp.dbz);
    end
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL dbz_latency: got %0d, want 2", lat);
    end
    applyStimulus(2'b00, 8'd1, 8'd2, 1'b0, obs, lat, bc, da);
    exp = expQ.pop_front();
    vectors++;
    if (obs !== exp || obs.dbz !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dbz_clear: got res=%h dbz=%b, want res=%h dbz=0", obs.res, obs.dbz, exp.res);
    end
  endtask

  task automatic test_zero_and_max;
    outs_t obs, exp; int lat, bc; logic da;
    logic [1:0] ops[8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};
    logic [7:0] as[8]  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd255};
    logic [7:0] bs[8]  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd1, 8'd1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(ops[i], as[i], bs[i], 1'b0, obs, lat, bc, da);
      exp = expQ.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL boundary_%0d (op=%b a=%0d b=%0d): got res=%h rem=%h neg=%b dbz=%b, want res=%h rem=%h neg=%b dbz=%b",
                 i, ops[i], as[i], bs[i], obs.res, obs.rem, obs.neg, obs.dbz, exp.res, exp.rem, exp.neg, exp.dbz);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    outs_t obs, exp; int lat, bc; logic da; bit sawDone;
    @(negedge clk);
    op = 2'b11; a = 8'd200; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || remainder !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_op: got busy=%b done=%b res=%h rem=%h, want 0/0/0000/00", busy, done, result, remainder);
    end
    clr = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) sawDone = 1'b1;
    end
    vectors++;
    if (sawDone !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_done: got activity=%b, want 0", sawDone);
    end
    applyStimulus(2'b00, 8'd12, 8'd34, 1'b0, obs, lat, bc, da);
    exp = expQ.pop_front();
    vectors++;
    if (obs !== exp || lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL add_after_abort: got res=%h lat=%0d, want res=%h lat=2", obs.res, lat, exp.res);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] ops[3] = '{2'b00, 2'b11, 2'b01};
    logic [7:0] as[3]  = '{8'd10, 8'd15, 8'd7};
    logic [7:0] bs[3]  = '{8'd20, 8'd17, 8'd9};
    outs_t exp, obs, last;
    int nDone = 0;
    int nextIdx = 1;
    bit prevBusy = 1'b0;
    bit gapCheck = 1'b0;
    last = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) expQ.push_back(calcModel(ops[i], as[i], bs[i]));
    op = ops[0]; a = as[0]; b = bs[0]; start = 1'b1;
    for (int cyc = 0; cyc < 80 && !(nDone == 3 && !gapCheck); cyc++) begin
      @(posedge clk); #1;
      if (gapCheck) begin
        obs = {result, remainder, negative, div_by_zero};
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || obs !== last) begin
          miscompares++;
          $display("[TB] FAIL b2b_gap_%0d: got busy=%b done=%b res=%h, want busy=0 done=0 res=%h",
                   nDone, busy, done, obs.res, last.res);
        end
        gapCheck = 1'b0;
      end
      if (busy && !prevBusy && nextIdx < 3) begin
        op = ops[nextIdx]; a = as[nextIdx]; b = bs[nextIdx];
        nextIdx++;
      end
      if (done) begin
        exp = expQ.pop_front();
        obs = {result, remainder, negative, div_by_zero};
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("[TB] FAIL b2b_result_%0d: got res=%h neg=%b, want res=%h neg=%b",
                   nDone, obs.res, obs.neg, exp.res, exp.neg);
        end
        last = exp;
        nDone++;
        gapCheck = 1'b1;
        if (nDone == 3) start = 1'b0;
      end
      prevBusy = busy;
    end
    start = 1'b0;
    vectors++;
    if (nDone !== 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d done pulses, want 3", nDone);
    end
  endtask

  // Run every scenario in sequence, then summarise
  initial begin
    clr = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_div_by_zero();
    test_zero_and_max();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
